id_hazard_unit: RTL and testbench
=================================

# id_hazard_unit

Pipeline hazard and stall controller for the 5-stage RV32 core. It is the producer side of the stall/flush interface: it drives the PC and pipeline-register write enables and bubble inserts that the EX-stage forwarding logic cannot resolve on its own. It covers three cases: load-use hazards, taken-branch flushes and data-memory wait states. It also supervises data-memory waits with a timeout and keeps saturating stall counters for performance debug.

## Interface
Parameters:
- TIMEOUT, 64: data-memory wait cycles allowed before the error state; minimum 2.
- CW, 16: width of the stall counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_use_rs1, ID_use_rs2  in  1 each  the ID instruction actually reads rs1 / rs2.
- EX_MemRead  in  1  the instruction in EX is a load.
- EX_RegWrite  in  1  the instruction in EX writes rd.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_branch_taken  in  1  branch or jump resolved taken in EX.
- dmem_req  in  1  the MEM stage has a valid load or store access.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_write, IFID_write, IDEX_write, EXMEM_write  out  1 each  register write enables.
- IFID_flush, IDEX_flush, MEMWB_flush  out  1 each  bubble inserts (zero the control fields).
- mem_timeout  out  1  sticky error flag.
- load_use_cnt, mem_wait_cnt  out  CW each  saturating stall counters.

## Operation
States:
- RUN
- WAIT: memory access outstanding.
- ERR: timeout reached.

The wait counter wcnt is ceil(log2(TIMEOUT+1)) bits.

Combinational terms:
- lu = EX_MemRead & EX_RegWrite & (EX_rd != 0) & ((ID_use_rs1 & EX_rd == ID_rs1) | (ID_use_rs2 & EX_rd == ID_rs2))
- mw = dmem_req & ~dmem_ready
- frz = mw | (state == ERR)

Output priority, highest first:
1. frz: all four write enables = 0, MEMWB_flush = 1, all other flushes = 0. The pipeline holds; EX_branch_taken and lu are ignored.
2. EX_branch_taken: all write enables = 1, IFID_flush = 1, IDEX_flush = 1. Any lu in the same cycle is dropped, because the ID instruction is squashed.
3. lu: PC_write = 0, IFID_write = 0, IDEX_write = 1, IDEX_flush = 1, EXMEM_write = 1. This inserts one bubble.
4. Otherwise: all write enables = 1, all flushes = 0.

State transitions:
- RUN -> WAIT when mw. Load wcnt = 1.
- WAIT -> RUN when dmem_ready is high or dmem_req is low. Clear wcnt.
- WAIT stays in WAIT while mw and wcnt < TIMEOUT; increment wcnt.
- WAIT -> ERR when mw and wcnt == TIMEOUT.
- ERR is absorbing until reset. mem_timeout = 1 in ERR (registered, so visible the cycle after entry).

Counters:
- load_use_cnt increments on every cycle that priority 3 is selected.
- mem_wait_cnt increments on every cycle where mw is high, in any state.
- Both counters saturate at all-ones and never wrap.

Register x0 never causes a hazard.

## Timing
- Reset (rst_n low, asynchronous): state = RUN, wcnt = 0, counters = 0, mem_timeout = 0.
- During reset the combinational outputs follow the RUN rules from the live inputs. With idle inputs this gives all write enables = 1 and all flushes = 0.
- Hazard outputs are combinational in the same cycle as their inputs: zero-cycle latency.
- A load-use stall lasts exactly one cycle. On the next edge the load advances to MEM and a bubble sits in EX, so lu falls naturally.
- A memory wait freezes the pipeline for N cycles while dmem_ready is low. The freeze releases in the cycle dmem_ready rises; that cycle the pipeline advances.
- A 1-cycle wait (dmem_ready already high on the first request cycle) causes no freeze and no state change.
- ERR is entered TIMEOUT+1 cycles after the first mw cycle if ready never arrives. From then on frz is held permanently.
- rst_n asserted mid-WAIT or in ERR returns to RUN immediately. mem_timeout clears asynchronously.
- A branch resolved while frozen takes effect in the first unfrozen cycle, because EX is held and EX_branch_taken stays asserted.

## Test plan
- Load-use hazard:
  - Stimulus: EX_MemRead = 1, EX_RegWrite = 1, EX_rd = 5, ID_rs2 = 5, ID_use_rs2 = 1.
  - Required: PC_write = 0, IFID_write = 0, IDEX_flush = 1 for one cycle; load_use_cnt goes 0 -> 1.
  - Repeat with EX_rd = 0, or with ID_use_rs2 = 0: no stall.
- Branch beats load-use:
  - Stimulus: lu true and EX_branch_taken = 1 together.
  - Required: IFID_flush = 1, IDEX_flush = 1, PC_write = 1; load_use_cnt unchanged.
- Memory wait:
  - Stimulus: dmem_req = 1, dmem_ready low for 3 cycles, then high.
  - Required: all write enables = 0 and MEMWB_flush = 1 for 3 cycles; state RUN -> WAIT -> RUN; mem_wait_cnt = 3; outputs back to normal in the ready cycle.
- Timeout, with TIMEOUT = 4:
  - Stimulus: dmem_ready held low.
  - Required: mem_timeout = 1 from the 6th cycle after the first wait cycle; freeze persists after dmem_ready later rises.
  - Then assert rst_n = 0 mid-cycle: mem_timeout = 0 and state = RUN immediately.
- Freeze beats hazards:
  - Stimulus: mw, lu and EX_branch_taken all high at once.
  - Required: only the freeze pattern is driven; the branch flush is driven in the first cycle after dmem_ready rises.
- Counter saturation, with CW = 2:
  - Stimulus: 5 consecutive load-use stall cycles.
  - Required: load_use_cnt = 3, no wrap.

Source files
------------

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: stall/flush controller for the 5-stage RV32 pipeline.
// Resolves load-use hazards, taken-branch squashes and data-memory wait
// states, supervises memory waits with a timeout, and keeps saturating
// stall counters for performance debug.
//
// Control outputs are purely combinational (zero-cycle latency), with this
// priority: freeze (memory wait or error) > taken branch > load-use > normal.
module id_hazard_unit #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [4:0]    ID_rs1,
  input  logic [4:0]    ID_rs2,
  input  logic          ID_use_rs1,
  input  logic          ID_use_rs2,
  input  logic          EX_MemRead,
  input  logic          EX_RegWrite,
  input  logic [4:0]    EX_rd,
  input  logic          EX_branch_taken,
  input  logic          dmem_req,
  input  logic          dmem_ready,
  output logic          PC_write,
  output logic          IFID_write,
  output logic          IDEX_write,
  output logic          EXMEM_write,
  output logic          IFID_flush,
  output logic          IDEX_flush,
  output logic          MEMWB_flush,
  output logic          mem_timeout,
  output logic [CW-1:0] load_use_cnt,
  output logic [CW-1:0] mem_wait_cnt,
  output logic [1:0]    o_dbg_state
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TO_MAX = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wcnt_next;
  logic          r_mem_timeout;
  logic [CW-1:0] r_lu_cnt;
  logic [CW-1:0] r_mw_cnt;

  logic w_lu;
  logic w_mw;
  logic w_frz;
  logic w_lu_sel;

  // Hazard terms; x0 is never a real dependency.
  assign w_lu = EX_MemRead & EX_RegWrite & (EX_rd != 5'd0) &
                ((ID_use_rs1 & (EX_rd == ID_rs1)) |
                 (ID_use_rs2 & (EX_rd == ID_rs2)));
  assign w_mw  = dmem_req & ~dmem_ready;
  assign w_frz = w_mw | (r_state == ST_ERR);
  // Load-use stall only wins when nothing of higher priority is active.
  assign w_lu_sel = w_lu & ~w_frz & ~EX_branch_taken;

  // State and wait-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // Next-state logic for memory-wait supervision; ERR is absorbing.
  always_comb begin
    w_next_state = r_state;
    w_wcnt_next  = r_wcnt;
    case (r_state)
      ST_RUN: begin
        if (w_mw) begin
          w_next_state = ST_WAIT;
          w_wcnt_next  = WW'(1);
        end
      end
      ST_WAIT: begin
        if (dmem_ready || !dmem_req) begin
          w_next_state = ST_RUN;
          w_wcnt_next  = '0;
        end else if (r_wcnt == TO_MAX) begin
          w_next_state = ST_ERR;
        end else begin
          w_wcnt_next = r_wcnt + WW'(1);
        end
      end
      ST_ERR: begin
        w_next_state = ST_ERR;
      end
      default: begin
        w_next_state = ST_RUN;
        w_wcnt_next  = '0;
      end
    endcase
  end

  // Pipeline enables and bubble inserts, highest priority first.
  always_comb begin
    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    EXMEM_write = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    MEMWB_flush = 1'b0;
    if (w_frz) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_write = 1'b0;
      MEMWB_flush = 1'b1;
    end else if (EX_branch_taken) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (w_lu) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IDEX_flush = 1'b1;
    end
  end

  // Sticky timeout flag, raised the cycle after ERR is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_timeout <= 1'b0;
    end else if (r_state == ST_ERR) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // Saturating stall counters for performance debug.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      if (w_lu_sel && (r_lu_cnt != {CW{1'b1}})) begin
        r_lu_cnt <= r_lu_cnt + CW'(1);
      end
      if (w_mw && (r_mw_cnt != {CW{1'b1}})) begin
        r_mw_cnt <= r_mw_cnt + CW'(1);
      end
    end
  end

  assign mem_timeout  = r_mem_timeout;
  assign load_use_cnt = r_lu_cnt;
  assign mem_wait_cnt = r_mw_cnt;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_id_hazard_unit.sv
// Bench for id_hazard_unit: two instances with TIMEOUT=4 share stimulus;
// dut_a has 16-bit counters, dut_b has 2-bit counters for saturation.
module tb_id_hazard_unit;

  // Expected control pattern {PC_w, IFID_w, IDEX_w, EXMEM_w, IFID_f, IDEX_f, MEMWB_f}
  localparam logic [6:0] C_NORM = 7'b1111_000;
  localparam logic [6:0] C_LU   = 7'b0011_010;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_FRZ  = 7'b0000_001;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;
  localparam int W = 44;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_regwrite;
  logic       ex_branch_taken, dmem_req, dmem_ready;

  logic        a_pc_w, a_ifid_w, a_idex_w, a_exmem_w, a_ifid_f, a_idex_f, a_memwb_f, a_to;
  logic [15:0] a_lu_cnt, a_mw_cnt;
  logic [1:0]  a_state;
  logic        b_pc_w, b_ifid_w, b_idex_w, b_exmem_w, b_ifid_f, b_idex_f, b_memwb_f, b_to;
  logic [1:0]  b_lu_cnt, b_mw_cnt;
  logic [1:0]  b_state;

  logic [W-1:0] exp_q[$];
  int total_cnt;
  int bad_cnt;

  id_hazard_unit #(.TIMEOUT(4), .CW(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(id_rs1), .ID_rs2(id_rs2),
    .ID_use_rs1(id_use_rs1), .ID_use_rs2(id_use_rs2),
    .EX_MemRead(ex_memread), .EX_RegWrite(ex_regwrite), .EX_rd(ex_rd),
    .EX_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_write(a_pc_w), .IFID_write(a_ifid_w), .IDEX_write(a_idex_w),
    .EXMEM_write(a_exmem_w),
    .IFID_flush(a_ifid_f), .IDEX_flush(a_idex_f), .MEMWB_flush(a_memwb_f),
    .mem_timeout(a_to), .load_use_cnt(a_lu_cnt), .mem_wait_cnt(a_mw_cnt),
    .o_dbg_state(a_state)
  );

  id_hazard_unit #(.TIMEOUT(4), .CW(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(id_rs1), .ID_rs2(id_rs2),
    .ID_use_rs1(id_use_rs1), .ID_use_rs2(id_use_rs2),
    .EX_MemRead(ex_memread), .EX_RegWrite(ex_regwrite), .EX_rd(ex_rd),
    .EX_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PC_write(b_pc_w), .IFID_write(b_ifid_w), .IDEX_write(b_idex_w),
    .EXMEM_write(b_exmem_w),
    .IFID_flush(b_ifid_f), .IDEX_flush(b_idex_f), .MEMWB_flush(b_memwb_f),
    .mem_timeout(b_to), .load_use_cnt(b_lu_cnt), .mem_wait_cnt(b_mw_cnt),
    .o_dbg_state(b_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got=running exp=done");
    $fatal(1, "watchdog");
  end

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pop the oldest expectation and compare it against the DUT outputs now
  task automatic compare_head();
    logic [W-1:0] e;
    logic [6:0]   a_ctrl;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    a_ctrl = {a_pc_w, a_ifid_w, a_idex_w, a_exmem_w, a_ifid_f, a_idex_f, a_memwb_f};
    chk("ctrl",         {25'd0, a_ctrl},   {25'd0, e[43:37]});
    chk("state",        {30'd0, a_state},  {30'd0, e[36:35]});
    chk("mem_timeout",  {31'd0, a_to},     {31'd0, e[34]});
    chk("load_use_cnt", {16'd0, a_lu_cnt}, {16'd0, e[33:18]});
    chk("mem_wait_cnt", {16'd0, a_mw_cnt}, {16'd0, e[17:2]});
    chk("sat_lu_cnt",   {30'd0, b_lu_cnt}, {30'd0, e[1:0]});
  endtask

  task automatic push_exp(input logic [6:0] ec, input logic [1:0] es, input logic eto,
                          input logic [15:0] elu, input logic [15:0] emw);
    logic [1:0] eb;
    eb = (elu > 16'd3) ? 2'd3 : elu[1:0];
    exp_q.push_back({ec, es, eto, elu, emw, eb});
  endtask

  // Driver: set all inputs at once
  task automatic set_in(input logic mr, input logic rw, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic br,
                        input logic req, input logic rdy);
    ex_memread = mr; ex_regwrite = rw; ex_rd = rd;
    id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
  endtask

  // One cycle: record expectation, sample mid-cycle, advance past the edge
  task automatic step(input logic [6:0] ec, input logic [1:0] es, input logic eto,
                      input logic [15:0] elu, input logic [15:0] emw);
    push_exp(ec, es, eto, elu, emw);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    push_exp(C_NORM, S_RUN, 0, 0, 0);
    compare_head();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load-use hazards and non-hazards
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(C_NORM, S_RUN, 0, 0, 0);
    set_in(1, 1, 5, 0, 5, 0, 1, 0, 0, 0); step(C_LU,   S_RUN, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(C_NORM, S_RUN, 0, 1, 0);
    set_in(1, 1, 0, 0, 0, 0, 1, 0, 0, 0); step(C_NORM, S_RUN, 0, 1, 0);
    set_in(1, 1, 5, 0, 5, 0, 0, 0, 0, 0); step(C_NORM, S_RUN, 0, 1, 0);
    set_in(1, 1, 7, 7, 3, 1, 0, 0, 0, 0); step(C_LU,   S_RUN, 0, 1, 0);
    // Branch beats load-use
    set_in(1, 1, 5, 0, 5, 0, 1, 1, 0, 0); step(C_BR,   S_RUN, 0, 2, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(C_NORM, S_RUN, 0, 2, 0);

    // Three-cycle memory wait
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(C_FRZ,  S_RUN,  0, 2, 0);
    step(C_FRZ, S_WAIT, 0, 2, 1);
    step(C_FRZ, S_WAIT, 0, 2, 2);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step(C_NORM, S_WAIT, 0, 2, 3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(C_NORM, S_RUN,  0, 2, 3);
    // Single-cycle access: no freeze, no state change
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step(C_NORM, S_RUN,  0, 2, 3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(C_NORM, S_RUN,  0, 2, 3);

    // Freeze beats branch and load-use; branch lands when ready rises
    set_in(1, 1, 5, 0, 5, 0, 1, 1, 1, 0); step(C_FRZ, S_RUN,  0, 2, 3);
    step(C_FRZ, S_WAIT, 0, 2, 4);
    set_in(1, 1, 5, 0, 5, 0, 1, 1, 1, 1); step(C_BR,  S_WAIT, 0, 2, 5);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(C_NORM, S_RUN, 0, 2, 5);

    // Timeout: ready never arrives
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(C_FRZ, S_RUN,  0, 2, 5);
    step(C_FRZ, S_WAIT, 0, 2, 6);
    step(C_FRZ, S_WAIT, 0, 2, 7);
    step(C_FRZ, S_WAIT, 0, 2, 8);
    step(C_FRZ, S_WAIT, 0, 2, 9);
    step(C_FRZ, S_ERR,  0, 2, 10);
    step(C_FRZ, S_ERR,  1, 2, 11);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step(C_FRZ, S_ERR, 1, 2, 12);
    set_in(1, 1, 5, 0, 5, 0, 1, 1, 0, 0); step(C_FRZ, S_ERR, 1, 2, 12);

    // Asynchronous reset out of ERR, mid-cycle
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    push_exp(C_NORM, S_RUN, 0, 0, 0);
    compare_head();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Five consecutive load-use cycles: 2-bit counter saturates at 3
    set_in(1, 1, 9, 9, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(C_LU, S_RUN, 0, 16'(i), 0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(C_NORM, S_RUN, 0, 5, 0);
    chk("sat_lu_final", {30'd0, b_lu_cnt}, 32'd3);

    // Randomised idle-ish traffic with no hazard: normal pattern throughout
    for (int i = 0; i < 8; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(1, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      step(C_NORM, S_RUN, 0, 5, 0);
    end

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
